// File: rtl/ft_recovery_ctrl_pkg.sv
// Shared types and default widths for the lockstep recovery sequencer.
// FAIL exists only when FT_RECOVERY_TIMEOUT_EN is defined.
package ft_pkg;

  localparam int ADDR_WIDTH_DEF   = 5;
  localparam int DATA_WIDTH_DEF   = 32;
  localparam int NUM_REGS_DEF     = 32;
  localparam int DRAIN_CYCLES_DEF = 4;
  localparam int CNT_WIDTH_DEF    = 8;
  localparam int TIMEOUT_DEF      = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HALT    = 3'd1,
    RESTORE = 3'd2,
    PC      = 3'd3,
    RESUME  = 3'd4
`ifdef FT_RECOVERY_TIMEOUT_EN
    ,
    FAIL    = 3'd5
`endif
  } rec_state_e;

  // Flat encodings used by the FSM itself; the enum is the debug view.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HALT    = 3'd1;
  localparam logic [2:0] ST_RESTORE = 3'd2;
  localparam logic [2:0] ST_PC      = 3'd3;
  localparam logic [2:0] ST_RESUME  = 3'd4;
`ifdef FT_RECOVERY_TIMEOUT_EN
  localparam logic [2:0] ST_FAIL    = 3'd5;
`endif

endpackage

// File: rtl/ft_recovery_ctrl_if.sv
// Bundle of comparator, shadow-file and core-restore signals around the
// recovery sequencer; master = sequencer, slave = surrounding datapath.
interface ft_recovery_ctrl_if
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) ();

  logic                  error_i;
  logic [ADDR_WIDTH-1:0] sgpr_raddr_o;
  logic [DATA_WIDTH-1:0] sgpr_rdata_i;
  logic                  rf_we_o;
  logic [ADDR_WIDTH-1:0] rf_waddr_o;
  logic [DATA_WIDTH-1:0] rf_wdata_o;
  logic [DATA_WIDTH-1:0] spc_i;
  // PC handshake: pc_valid_o holds with a stable pc_restore_o until a cycle
  // where pc_ack_i is also high; that cycle is the transfer. pc_ack_i is
  // ignored whenever pc_valid_o is low.
  logic [DATA_WIDTH-1:0] pc_restore_o;
  logic                  pc_valid_o;
  logic                  pc_ack_i;
  logic                  fetch_block_o;
  logic                  busy_o;
  logic [CNT_WIDTH-1:0]  recovery_cnt_o;
  logic                  fatal_o;
  rec_state_e            state_dbg;

  modport master (
    input  error_i, sgpr_rdata_i, spc_i, pc_ack_i,
    output sgpr_raddr_o, rf_we_o, rf_waddr_o, rf_wdata_o, pc_restore_o,
           pc_valid_o, fetch_block_o, busy_o, recovery_cnt_o, fatal_o,
           state_dbg
  );

  modport slave (
    output error_i, sgpr_rdata_i, spc_i, pc_ack_i,
    input  sgpr_raddr_o, rf_we_o, rf_waddr_o, rf_wdata_o, pc_restore_o,
           pc_valid_o, fetch_block_o, busy_o, recovery_cnt_o, fatal_o,
           state_dbg
  );

endinterface

// File: rtl/ft_recovery_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module ft_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      count_o <= '0;
    end else if (clr_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/ft_recovery_ctrl.sv
// Lockstep recovery sequencer: halt/drain, replay shadow GPRs, restore PC, resume.
// Optional PC-ack watchdog and sticky FAIL state under FT_RECOVERY_TIMEOUT_EN.
module ft_recovery_ctrl
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int NUM_REGS     = NUM_REGS_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input logic                clk_i,
  input logic                rst_n,
  ft_recovery_ctrl_if.master bus
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_FIRST  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST   = ADDR_WIDTH'(NUM_REGS - 1);

  logic [2:0]            state_q, state_d;
  logic [DRAIN_W-1:0]    drain_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  pending_q;
  logic [DATA_WIDTH-1:0] spc_q;
  logic                  halt_entry;
  logic                  timeout_hit;
  logic [CNT_WIDTH-1:0]  rec_cnt;

`ifdef FT_RECOVERY_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  // Counts PC cycles without an ack; the TIMEOUT-th such cycle trips FAIL.
  ft_sat_counter #(.WIDTH(WD_W)) u_watchdog (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .clr_i   (state_q != ST_PC),
    .inc_i   ((state_q == ST_PC) && !bus.pc_ack_i),
    .count_o (wd_cnt)
  );

  assign timeout_hit = (state_q == ST_PC) && !bus.pc_ack_i &&
                       (wd_cnt == WD_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.error_i) state_d = ST_HALT;
      ST_HALT:    if (drain_q == DRAIN_LAST) state_d = ST_RESTORE;
      ST_RESTORE: if (idx_q == IDX_LAST) state_d = ST_PC;
      ST_PC: begin
        if (bus.pc_ack_i) begin
          state_d = ST_RESUME;
        end else if (timeout_hit) begin
`ifdef FT_RECOVERY_TIMEOUT_EN
          state_d = ST_FAIL;
`endif
        end
      end
      // An error seen in RESUME itself counts as pending, so no IDLE gap.
      ST_RESUME:  state_d = (pending_q || bus.error_i) ? ST_HALT : ST_IDLE;
`ifdef FT_RECOVERY_TIMEOUT_EN
      ST_FAIL:    state_d = ST_FAIL;
`endif
      default:    state_d = ST_IDLE;
    endcase
  end

  assign halt_entry = (state_d == ST_HALT) && (state_q != ST_HALT);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      drain_q   <= '0;
      idx_q     <= IDX_FIRST;
      pending_q <= 1'b0;
      spc_q     <= '0;
    end else begin
      state_q <= state_d;
      if (halt_entry) spc_q <= bus.spc_i;
      drain_q <= (state_q == ST_HALT) ? drain_q + 1'b1 : '0;
      idx_q   <= (state_q == ST_RESTORE) ? idx_q + 1'b1 : IDX_FIRST;
      if (state_q == ST_RESUME) begin
        pending_q <= 1'b0;
      end else if ((state_q != ST_IDLE) && bus.error_i) begin
        pending_q <= 1'b1;
      end
    end
  end

  ft_sat_counter #(.WIDTH(CNT_WIDTH)) u_rec_cnt (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .clr_i   (1'b0),
    .inc_i   (state_q == ST_RESUME),
    .count_o (rec_cnt)
  );

  logic                  fetch_block, busy, rf_we, pc_valid, fatal;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] wdata, pc_restore;

  always_comb begin
    fetch_block = 1'b0;
    busy        = 1'b0;
    rf_we       = 1'b0;
    pc_valid    = 1'b0;
    fatal       = 1'b0;
    raddr       = '0;
    wdata       = '0;
    pc_restore  = '0;
    case (state_q)
      ST_HALT: begin
        fetch_block = 1'b1;
        busy        = 1'b1;
      end
      ST_RESTORE: begin
        fetch_block = 1'b1;
        busy        = 1'b1;
        rf_we       = 1'b1;
        raddr       = idx_q;
        wdata       = bus.sgpr_rdata_i;
      end
      ST_PC: begin
        fetch_block = 1'b1;
        busy        = 1'b1;
        pc_valid    = 1'b1;
        pc_restore  = spc_q;
      end
      ST_RESUME: busy = 1'b1;
`ifdef FT_RECOVERY_TIMEOUT_EN
      ST_FAIL: begin
        fetch_block = 1'b1;
        busy        = 1'b1;
        fatal       = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.sgpr_raddr_o   = raddr;
  assign bus.rf_we_o        = rf_we;
  assign bus.rf_waddr_o     = raddr;
  assign bus.rf_wdata_o     = wdata;
  assign bus.pc_restore_o   = pc_restore;
  assign bus.pc_valid_o     = pc_valid;
  assign bus.fetch_block_o  = fetch_block;
  assign bus.busy_o         = busy;
  assign bus.recovery_cnt_o = rec_cnt;
  assign bus.fatal_o        = fatal;
  assign bus.state_dbg      = rec_state_e'(state_q);

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Self-checking bench for ft_recovery_ctrl: random shadow contents and ack
// delays, a write scoreboard, and a 2-bit-counter twin for saturation.
module tb_ft_recovery_ctrl;
  import ft_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int DC = 4;
  localparam int CW = 8;
  localparam int SW = 2;
  localparam int TO = 64;
  localparam int QW = AW + DW;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk_i = ~clk_i;

  ft_recovery_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
  ft_recovery_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(SW)) bus_s ();

  ft_recovery_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
                     .DRAIN_CYCLES(DC), .CNT_WIDTH(CW), .TIMEOUT(TO))
    dut (.clk_i(clk_i), .rst_n(rst_n), .bus(bus));

  ft_recovery_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
                     .DRAIN_CYCLES(DC), .CNT_WIDTH(SW), .TIMEOUT(TO))
    dut_s (.clk_i(clk_i), .rst_n(rst_n), .bus(bus_s));

  logic [DW-1:0] sgpr [NR];
  assign bus.sgpr_rdata_i   = sgpr[bus.sgpr_raddr_o];
  assign bus_s.sgpr_rdata_i = sgpr[bus_s.sgpr_raddr_o];
  assign bus_s.error_i      = bus.error_i;
  assign bus_s.spc_i        = bus.spc_i;
  assign bus_s.pc_ack_i     = bus.pc_ack_i;

  // ---------------- scoreboard / model state ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [QW-1:0] exp_q[$];
  int            recov_total = 0;
  logic [DW-1:0] entry_pc;
  logic          pend_exp = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge clk_i) begin
    if (bus.rf_we_o === 1'b1) begin
      check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0)
        check("wr_addr_data", 64'({bus.rf_waddr_o, bus.rf_wdata_o}), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic randomize_sgpr();
    for (int i = 0; i < NR; i++) sgpr[i] = $urandom;
  endtask

  task automatic push_recovery();
    for (int r = 1; r < NR; r++) exp_q.push_back({AW'(r), sgpr[r]});
  endtask

  task automatic check_cnt(input string tag);
    check(tag, 64'(bus.recovery_cnt_o), 64'(sat(recov_total, CW)));
    check({tag, "_sat2"}, 64'(bus_s.recovery_cnt_o), 64'(sat(recov_total, SW)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    64'(bus.rf_we_o), 64'd0);
    check({tag, "_fb"},    64'(bus.fetch_block_o), 64'd0);
    check({tag, "_busy"},  64'(bus.busy_o), 64'd0);
    check({tag, "_pcv"},   64'(bus.pc_valid_o), 64'd0);
    check({tag, "_pc"},    64'(bus.pc_restore_o), 64'd0);
    check({tag, "_raddr"}, 64'(bus.sgpr_raddr_o), 64'd0);
    check({tag, "_wdata"}, 64'(bus.rf_wdata_o), 64'd0);
    check({tag, "_cnt"},   64'(bus.recovery_cnt_o), 64'd0);
    check({tag, "_fatal"}, 64'(bus.fatal_o), 64'd0);
    check({tag, "_state"}, 64'(bus.state_dbg), 64'(IDLE));
  endtask

  task automatic trigger();
    check("pre_busy", 64'(bus.busy_o), 64'd0);
    bus.error_i = 1'b1;
    entry_pc = bus.spc_i;
    push_recovery();
    step();
    bus.error_i = 1'b0;
    check("fb_rise", 64'(bus.fetch_block_o), 64'd1);
    check("busy_rise", 64'(bus.busy_o), 64'd1);
  endtask

  // Walks HALT and RESTORE; returns 0 if a reset was injected at rst_idx.
  task automatic halt_restore(input int err_idx, input int stray_idx, input int rst_idx,
                              output bit done);
    done = 1'b0;
    for (int d = 0; d < DC; d++) begin
      check("halt_fb", 64'(bus.fetch_block_o), 64'd1);
      check("halt_we", 64'(bus.rf_we_o), 64'd0);
      step();
    end
    for (int i = 1; i < NR; i++) begin
      check("rs_we", 64'(bus.rf_we_o), 64'd1);
      check("rs_raddr", 64'(bus.sgpr_raddr_o), 64'(i));
      check("rs_pcv", 64'(bus.pc_valid_o), 64'd0);
      if (i == rst_idx) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        exp_q.delete();
        recov_total = 0;
        pend_exp = 1'b0;
        step(2);
        rst_n = 1'b1;
        return;
      end
      if (i == 5) bus.spc_i = $urandom;
      if (i == err_idx) begin
        bus.error_i = 1'b1;
        pend_exp = 1'b1;
        push_recovery();
      end
      if (i == stray_idx) bus.pc_ack_i = 1'b1;
      step();
      bus.error_i = 1'b0;
      bus.pc_ack_i = 1'b0;
    end
    done = 1'b1;
  endtask

  task automatic pc_resume(input int ack_delay);
    logic [DW-1:0] next_pc;
    for (int w = 0; w <= ack_delay; w++) begin
      check("pc_valid", 64'(bus.pc_valid_o), 64'd1);
      check("pc_value", 64'(bus.pc_restore_o), 64'(entry_pc));
      check("pc_fb", 64'(bus.fetch_block_o), 64'd1);
      check("pc_fatal", 64'(bus.fatal_o), 64'd0);
      if (w == ack_delay) bus.pc_ack_i = 1'b1;
      step();
      bus.pc_ack_i = 1'b0;
    end
    check("resume_fb", 64'(bus.fetch_block_o), 64'd0);
    check("resume_busy", 64'(bus.busy_o), 64'd1);
    check("resume_pcv", 64'(bus.pc_valid_o), 64'd0);
    check_cnt("resume_cnt");
    next_pc = bus.spc_i;
    step();
    recov_total++;
    check_cnt("cnt_after");
    if (pend_exp) begin
      check("pend_rehalt", 64'(bus.fetch_block_o), 64'd1);
      entry_pc = next_pc;
      pend_exp = 1'b0;
    end else begin
      check("idle_busy", 64'(bus.busy_o), 64'd0);
    end
  endtask

  task automatic run_seq(input int ack_delay, input int err_idx, input int stray_idx,
                         input int rst_idx);
    bit done;
    halt_restore(err_idx, stray_idx, rst_idx, done);
    if (done) pc_resume(ack_delay);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.error_i  = 1'b0;
    bus.pc_ack_i = 1'b0;
    bus.spc_i    = 32'h0000_1040;
    randomize_sgpr();

    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    step(2);
    rst_n = 1'b1;
    step(2);
    check_all_zero("post_reset");

    // single error, ack two cycles after pc_valid
    trigger();
    run_seq(2, 0, 0, 0);

    // stray ack while idle
    bus.pc_ack_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stray_idle_pcv", 64'(bus.pc_valid_o), 64'd0);
      check("stray_idle_state", 64'(bus.state_dbg), 64'(IDLE));
    end
    bus.pc_ack_i = 1'b0;

    // error at index 10 plus stray ack at index 12; pending recovery follows
    randomize_sgpr();
    bus.spc_i = $urandom;
    trigger();
    run_seq(int'($urandom_range(0, 3)), 10, 12, 0);
    run_seq(int'($urandom_range(0, 3)), 0, 0, 0);
    check("two_rec_cnt", 64'(bus.recovery_cnt_o), 64'd3);

    // reset in the middle of RESTORE
    randomize_sgpr();
    trigger();
    run_seq(0, 0, 0, 7);
    step(12);
    check("after_rst_busy", 64'(bus.busy_o), 64'd0);
    check("after_rst_cnt", 64'(bus.recovery_cnt_o), 64'd0);

    // five random recoveries; the 2-bit twin saturates at 3
    for (int k = 0; k < 5; k++) begin
      randomize_sgpr();
      bus.spc_i = $urandom;
      trigger();
      run_seq(int'($urandom_range(0, 5)), 0, 0, 0);
      step(int'($urandom_range(0, 3)));
    end
    check("five_cnt", 64'(bus.recovery_cnt_o), 64'd5);
    check("five_cnt_sat2", 64'(bus_s.recovery_cnt_o), 64'd3);

    // ack withheld for 100 cycles
    randomize_sgpr();
    bus.spc_i = $urandom;
    trigger();
`ifdef FT_RECOVERY_TIMEOUT_EN
    begin
      bit done;
      halt_restore(0, 0, 0, done);
      for (int w = 0; w < TO; w++) begin
        check("wd_pcv", 64'(bus.pc_valid_o), 64'd1);
        check("wd_fatal", 64'(bus.fatal_o), 64'd0);
        step();
      end
      for (int w = 0; w < 36; w++) begin
        check("fail_fatal", 64'(bus.fatal_o), 64'd1);
        check("fail_pcv", 64'(bus.pc_valid_o), 64'd0);
        check("fail_fb", 64'(bus.fetch_block_o), 64'd1);
        check("fail_busy", 64'(bus.busy_o), 64'd1);
        step();
      end
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step();
      check("fail_cleared", 64'(bus.fatal_o), 64'd0);
    end
`else
    run_seq(100, 0, 0, 0);
`endif

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL sim_timeout: run did not finish in time");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "simulation time limit");
  end

endmodule
